// File: rtl/key_control_fsm_if.sv
// Key/control bundle between the stopwatch keypad front end and its consumer.
// The slave side is the key_control_fsm block: it receives the raw keys and
// drives the counter-control outputs.
interface key_control_fsm_if;
  logic       key_start;
  logic       key_pause;
  logic       key_load;
  logic       EN;
  logic       clr;
  logic       load;
  logic [1:0] state;

  modport master (
    output key_start, key_pause, key_load,
    input  EN, clr, load, state
  );

  modport slave (
    input  key_start, key_pause, key_load,
    output EN, clr, load, state
  );
endinterface

// File: rtl/key_control_fsm.sv
// Stopwatch key front end: synchronise and debounce three active-low keys,
// turn each press into a one-cycle event, and sequence the counter controls.
//
//   state   | meaning
//   --------+-------------------------------------------
//   IDLE    | count held, waiting for start or load
//   RUN     | counting, EN high
//   PAUSE   | count frozen, pause resumes, start stops
//   STOPPED | count frozen, start clears, load presets
module key_control_fsm #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int DB_W      = 20
) (
  input  logic             clk_50Mhz,
  input  logic             rst,
  key_control_fsm_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] PAUSE   = 2'd2;
  localparam logic [1:0] STOPPED = 2'd3;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // Key index: 0 = start, 1 = pause, 2 = load.
  logic [2:0]      w_keys;
  logic [2:0]      r_s1;
  logic [2:0]      r_s2;
  logic [2:0]      r_stable;
  logic [2:0]      r_stable_d;
  logic [2:0]      r_press;
  logic [2:0]      r_armed;
  logic [DB_W-1:0] r_cnt [3];
  logic [1:0]      r_flush;
  logic            w_flush_done;

  logic [1:0]      r_state;
  logic            r_en;
  logic            r_clr;
  logic            r_load;
  logic [1:0]      w_next;
  logic            w_clr;
  logic            w_load;

  assign w_keys       = {bus.key_load, bus.key_pause, bus.key_start};
  assign w_flush_done = (r_flush == 2'd2);

  // Count the edges needed for the synchroniser to carry real key levels.
  always_ff @(posedge clk_50Mhz or negedge rst) begin
    if (!rst) begin
      r_flush <= 2'd0;
    end else if (!w_flush_done) begin
      r_flush <= r_flush + 2'd1;
    end
  end

  // Synchronise, debounce and edge-detect every key. A key only becomes
  // armed once it has been seen released after reset, so a key held through
  // reset release cannot produce a press.
  always_ff @(posedge clk_50Mhz or negedge rst) begin
    if (!rst) begin
      r_s1       <= '1;
      r_s2       <= '1;
      r_stable   <= '1;
      r_stable_d <= '1;
      r_press    <= '0;
      r_armed    <= '0;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_s1       <= w_keys;
      r_s2       <= r_s1;
      r_stable_d <= r_stable;
      r_press    <= r_armed & r_stable_d & ~r_stable;
      for (int i = 0; i < 3; i++) begin
        if (w_flush_done && r_s2[i]) r_armed[i] <= 1'b1;
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Next-state decode: only the highest-priority event of a cycle is used.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_load = 1'b0;
    if (r_press[0]) begin
      case (r_state)
        IDLE:    w_next = RUN;
        RUN:     w_next = STOPPED;
        PAUSE:   w_next = STOPPED;
        default: begin
          w_next = IDLE;
          w_clr  = 1'b1;
        end
      endcase
    end else if (r_press[1]) begin
      if (r_state == RUN)        w_next = PAUSE;
      else if (r_state == PAUSE) w_next = RUN;
    end else if (r_press[2]) begin
      if (r_state == IDLE || r_state == STOPPED) begin
        w_next = IDLE;
        w_load = 1'b1;
      end
    end
  end

  // Register state and all counter-control outputs together.
  always_ff @(posedge clk_50Mhz or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_en    <= 1'b0;
      r_clr   <= 1'b0;
      r_load  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_en    <= (w_next == RUN);
      r_clr   <= w_clr;
      r_load  <= w_load;
    end
  end

  assign bus.state = r_state;
  assign bus.EN    = r_en;
  assign bus.clr   = r_clr;
  assign bus.load  = r_load;

endmodule
